uart_tx_frame_ser: RTL and testbench

//  Parametrised UART transmit serializer. FSM, bit counter, parity generator and registered output mux in one block.

---
 rtl/uart_tx_frame_ser.sv | 150 +++++++++++++++
 tb/tb_uart_tx_frame_ser.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ser.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1..2 stop bits.
// Bit timing comes from the external bit_tick strobe. All outputs are registered.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, the block
// honours par_en/par_typ and adds the PARITY state.
module uart_tx_frame_ser #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  bit_tick,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ack,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  tx_n, busy_n, ack_n;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  logic par_bit, par_bit_n;
  logic par_on, par_on_n;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = par_en ^ par_typ;
`endif

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      data_ack <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
      par_on   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      tx_out   <= tx_n;
      busy     <= busy_n;
      data_ack <= ack_n;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_bit_n;
      par_on   <= par_on_n;
`endif
    end
  end

  // Next-state and next-output logic; acceptance from IDLE and from the final
  // stop tick share one load path so back-to-back frames have no idle gap
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    tx_n      = tx_out;
    busy_n    = busy;
    ack_n     = 1'b0;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_bit_n = par_bit;
    par_on_n  = par_on;
`endif
    if (bit_tick) begin
      case (state)
        IDLE: begin
          if (data_valid) load = 1'b1;
        end
        START: begin
          state_n = DATA;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
          cnt_n   = '0;
        end
        DATA: begin
          if (cnt < 4'(DATA_WIDTH - 1)) begin
            cnt_n   = cnt + 4'd1;
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end else begin
            cnt_n   = '0;
            state_n = STOP;
            tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_on) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_n = STOP;
          tx_n    = 1'b1;
          cnt_n   = '0;
        end
`endif
        STOP: begin
          if (cnt < 4'(STOP_BITS - 1)) begin
            cnt_n = cnt + 4'd1;
          end else if (data_valid) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    if (load) begin
      state_n   = START;
      shreg_n   = p_data;
      tx_n      = 1'b0;
      busy_n    = 1'b1;
      ack_n     = 1'b1;
      cnt_n     = '0;
`ifdef UART_TX_PARITY_EN
      par_on_n  = par_en;
      par_bit_n = (^p_data) ^ par_typ;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ser.sv
// Self-checking bench for uart_tx_frame_ser (8-bit data, 1 and 2 stop bits).
module tb_uart_tx_frame_ser;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          bit_tick;
  logic [DW-1:0] p_data;
  logic          data_valid, data_valid2;
  logic          par_en, par_typ;
  logic          ack1, tx1, busy1;
  logic          ack2, tx2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_ser #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
    .CLK(CLK), .RST(RST), .bit_tick(bit_tick), .p_data(p_data),
    .data_valid(data_valid), .data_ack(ack1), .par_en(par_en),
    .par_typ(par_typ), .tx_out(tx1), .busy(busy1)
  );

  uart_tx_frame_ser #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .bit_tick(bit_tick), .p_data(p_data),
    .data_valid(data_valid2), .data_ack(ack2), .par_en(par_en),
    .par_typ(par_typ), .tx_out(tx2), .busy(busy2)
  );

  // Reference frame: start, data LSB first, optional parity, stop bits
  function automatic int build_frame(input logic [DW-1:0] d, input bit pen,
                                     input bit ptyp, input int sb,
                                     output bit bits[16]);
    int n = 0;
    int ones = 0;
    bits = '{default: 1'b1};
    bits[n++] = 1'b0;
    for (int i = 0; i < DW; i++) begin
      bits[n++] = d[i];
      if (d[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    if (pen) bits[n++] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
`endif
    for (int i = 0; i < sb; i++) bits[n++] = 1'b1;
    return n;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d: tx/busy/ack got %b expected %b", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [2:0] observe(input bit sel);
    return sel ? {tx2, busy2, ack2} : {tx1, busy1, ack1};
  endfunction

  // Sends n words with data_valid held throughout, ticks every 'period' cycles,
  // and checks every cycle until the line returns to idle
  task automatic run_frames(input logic [DW-1:0] words[4], input int n,
                            input bit pen, input bit ptyp, input int period,
                            input bit sel, input string tag);
    bit bits[16];
    int len, flen, total, f, o;
    logic [2:0] exp;
    len   = build_frame(words[0], pen, ptyp, sel ? 2 : 1, bits);
    flen  = len * period;
    total = n * flen;
    p_data  = words[0];
    par_en  = pen;
    par_typ = ptyp;
    if (sel) data_valid2 = 1'b1; else data_valid = 1'b1;
    for (int e = 0; e <= total; e++) begin
      bit_tick = ((e % period) == 0);
      @(posedge CLK); #1;
      f = e / flen;
      o = e % flen;
      if (f < n) begin
        void'(build_frame(words[f], pen, ptyp, sel ? 2 : 1, bits));
        exp = {bits[o / period], 1'b1, (o == 0)};
      end else begin
        exp = 3'b100;
      end
      chk(tag, e, observe(sel), exp);
      if (f < n && o == 0) begin
        if (f < n - 1) begin
          p_data = words[f + 1];
        end else begin
          data_valid  = 1'b0;
          data_valid2 = 1'b0;
          p_data  = DW'($urandom);
          par_en  = ~pen;
          par_typ = 1'($urandom);
        end
      end
    end
    bit_tick = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w[4];
    bit bits[16];
    int n, period;
    bit pen, ptyp, sel;

    // Reset held with data_valid asserted: nothing may start
    RST = 1'b1; data_valid = 1'b1; data_valid2 = 1'b1; bit_tick = 1'b1;
    p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      chk("reset_sb1", i, observe(1'b0), 3'b100);
      chk("reset_sb2", i, observe(1'b1), 3'b100);
    end
    RST = 1'b0; data_valid = 1'b0; data_valid2 = 1'b0; bit_tick = 1'b0;
    @(posedge CLK); #1;
    chk("idle_no_tick", 0, observe(1'b0), 3'b100);

    w = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frames(w, 1, 1'b0, 1'b0, 1, 1'b0, "8n1_a5");
    run_frames(w, 1, 1'b1, 1'b0, 1, 1'b0, "par_even_a5");
    run_frames(w, 1, 1'b1, 1'b1, 1, 1'b0, "par_odd_a5");
    run_frames(w, 1, 1'b0, 1'b0, 4, 1'b1, "tick4_sb2");

    w = '{8'h00, 8'hFF, 8'h00, 8'h00};
    run_frames(w, 2, 1'b0, 1'b0, 1, 1'b0, "back2back");

    // Reset while the 4th data bit is on the line
    p_data = 8'h3C; par_en = 1'b0; data_valid = 1'b1; bit_tick = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(posedge CLK); #1;
      void'(build_frame(8'h3C, 1'b0, 1'b0, 1, bits));
      chk("pre_rst", e, observe(1'b0), {bits[e], 1'b1, (e == 0)});
      data_valid = 1'b0;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst", 0, observe(1'b0), 3'b100);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_idle", 0, observe(1'b0), 3'b100);
    bit_tick = 1'b0;
    w = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_frames(w, 1, 1'b0, 1'b0, 1, 1'b0, "after_rst");

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
      n      = $urandom_range(1, 3);
      period = $urandom_range(1, 3);
      pen    = 1'($urandom);
      ptyp   = 1'($urandom);
      sel    = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      run_frames(w, n, pen, ptyp, period, sel, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
